// File: rtl/iter_alu_if.sv
// iter_alu_if: request/response bundle between the control unit and iter_alu.
//   master : drives start, op, a_in, b_in; observes busy/done/result/flags
//   slave  : the ALU side of the same bundle
// WIDTH sets the operand/result width and must match the ALU instance.
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
    logic             ovf;
    logic             dz;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, zero, sign, ovf, dz
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, zero, sign, ovf, dz
    );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with a start/done handshake.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : iter_alu_if.slave (start/op/a_in/b_in in; busy/done/result/
//           zero/sign/ovf/dz out)
// Single-cycle ops (ADD SUB AND OR XOR SLL SRL SLT) finish one cycle after
// acceptance; MUL/MULHU (and DIVU/REMU when built) take WIDTH+1 cycles.
// Build option: define ITER_ALU_DIV_EN to include the restoring divider;
// without it DIVU/REMU decode as unknown ops (result 0, single-cycle).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterative multiply/divide, one step per cycle
// DONE  | result valid, done high for this cycle
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    iter_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
`ifdef ITER_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic               dz_q;

    logic [WIDTH-1:0]   sc_result;
    logic               sc_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               is_iter;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   iter_result;
    logic               iter_dz;

`ifdef ITER_ALU_DIV_EN
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
`endif

    // Single-cycle ops are computed straight from the bus at the accepting edge.
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sum       = bus.a_in + bus.b_in;
        diff      = bus.a_in - bus.b_in;
        case (bus.op)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.a_in[WIDTH-1]);
            end
            OP_AND:  sc_result = bus.a_in & bus.b_in;
            OP_OR:   sc_result = bus.a_in | bus.b_in;
            OP_XOR:  sc_result = bus.a_in ^ bus.b_in;
            OP_SLL:  sc_result = bus.b_in << bus.a_in[SHW-1:0];
            OP_SRL:  sc_result = bus.b_in >> bus.a_in[SHW-1:0];
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}},
                                  ($signed(bus.a_in) < $signed(bus.b_in))};
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        is_iter = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
`ifdef ITER_ALU_DIV_EN
        is_iter = is_iter || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
`endif
    end

    // Shift-add multiply: the upper half accumulates, the lower half holds the
    // not-yet-consumed multiplier bits and fills with product bits.
    always_comb begin
        mul_add   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, a_q} : '0);
        prod_next = {mul_add, prod_q[WIDTH-1:1]};
    end

`ifdef ITER_ALU_DIV_EN
    // Restoring divide: quo_q starts as the dividend and is shifted out MSB
    // first while quotient bits shift in. A zero divisor always "fits", which
    // yields all-ones quotient and remainder = dividend without special casing.
    always_comb begin
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = div_shift[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        iter_result = prod_next[WIDTH-1:0];
        iter_dz     = 1'b0;
        case (op_q)
            OP_MULHU: iter_result = prod_next[2*WIDTH-1:WIDTH];
`ifdef ITER_ALU_DIV_EN
            OP_DIVU: begin
                iter_result = quo_next;
                iter_dz     = (b_q == '0);
            end
            OP_REMU: begin
                iter_result = rem_next;
                iter_dz     = (b_q == '0);
            end
`endif
            default: iter_result = prod_next[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
`ifdef ITER_ALU_DIV_EN
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.a_in;
`ifdef ITER_ALU_DIV_EN
                        b_q  <= bus.b_in;
`endif
                        if (is_iter) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            count  <= CW'(WIDTH);
                            prod_q <= {{WIDTH{1'b0}}, bus.b_in};
`ifdef ITER_ALU_DIV_EN
                            rem_q  <= '0;
                            quo_q  <= bus.a_in;
`endif
                        end else begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= sc_result;
                            ovf_q    <= sc_ovf;
                            dz_q     <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    prod_q <= prod_next;
`ifdef ITER_ALU_DIV_EN
                    rem_q  <= rem_next;
                    quo_q  <= quo_next;
`endif
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= iter_result;
                        ovf_q    <= 1'b0;
                        dz_q     <= iter_dz;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);
    assign bus.sign   = result_q[WIDTH-1];
    assign bus.ovf    = ovf_q;
    assign bus.dz     = dz_q;
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised multi-cycle ALU for the next CPU generation (multi-cycle/pipelined core).
- Keeps the single-cycle op set and encodings, and adds SRL, XOR, an iterative multiply and an optional iterative divide.
- Uses a start/done handshake so the control unit can stall on long ops.
- Sits between the register-read stage and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from the LSBs of a_in.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  4  operation code (see Behaviour).
- a_in  input  WIDTH  operand A (shift amount for shift ops).
- b_in  input  WIDTH  operand B (value shifted for shift ops).
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse: result valid and updated.
- result  output  WIDTH  registered result, held until the next done.
- zero  output  1  result == 0 (full-width compare).
- sign  output  1  result[WIDTH-1].
- ovf  output  1  signed overflow of the last ADD/SUB, else 0.
- dz  output  1  last DIVU/REMU had b_in == 0, else 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, ovf=0, dz=0, counter=0. zero therefore reads 1. A reset mid-op aborts it; no done is produced.
- Operands and op are latched on the accepting edge; later input changes have no effect on the op in flight.
- Op codes:
  - 0010 ADD: a+b.
  - 0110 SUB: a-b.
  - 0000 AND.
  - 0001 OR.
  - 0100 XOR.
  - 0011 SLL: b << a[SHW-1:0].
  - 0101 SRL: b >> a[SHW-1:0], logical.
  - 0111 SLT: signed a<b -> 1 else 0.
  - 1000 MUL: low WIDTH bits of unsigned a*b.
  - 1001 MULHU: high WIDTH bits of unsigned a*b.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
  - Any other code: result=0, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. ovf is set on ADD when operand signs are equal and the result sign differs; on SUB when operand signs differ and the result sign differs from a.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE with start=1 and a single-cycle op -> DONE. result is written at that edge; done=1 in the following cycle (latency 1).
  - IDLE/DONE with start=1 and MUL/MULHU/DIVU/REMU -> RUN, counter=WIDTH, busy=1.
  - RUN: one shift-add (MUL) or one restoring-divide step (DIV) per cycle; counter decrements. When counter reaches 1, next state is DONE and result is written. Total latency is WIDTH+1 cycles from the accepting edge to the done pulse.
  - DONE with start=0 -> IDLE. done is high exactly one cycle per DONE entry.
- start while busy=1 is ignored and not queued.
- Back-to-back: start held high in DONE is accepted, so a single-cycle op stream yields done every cycle.
- Multiplier/divider datapath: 2*WIDTH-bit product register; WIDTH-bit remainder and quotient registers.
- Divide by zero: quotient is all ones, remainder = a, dz=1. It takes the full WIDTH cycles, with no early exit.
- ovf and dz update only on done; each is cleared by any completing op that does not set it.

Optional Feature:
- Macro: ITER_ALU_DIV_EN.
- Defined: DIVU/REMU are implemented as described above.
- Undefined: no divider logic is built. DIVU/REMU behave as unknown codes: single-cycle, result=0, dz stays 0.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> busy=0, done=0, result=0, zero=1 immediately, with no clock edge needed.
- ADD overflow: op=0010, a=0x7FFFFFFF, b=1 -> one cycle later done=1, result=0x80000000, sign=1, ovf=1; next cycle done=0.
- Shift/SLT back-to-back: SLL a=4, b=0x1, then SLT a=0xFFFFFFFF, b=0 on consecutive cycles -> done on two consecutive cycles, results 0x10 then 1.
- MUL/MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - MUL -> busy for 32 cycles, done at cycle 33, result=0x00000001.
  - MULHU -> result=0xFFFFFFFE.
  - A start pulsed mid-run is ignored.
- DIV (macro defined):
  - DIVU a=100, b=7 -> result=14.
  - REMU a=100, b=7 -> result=2.
  - DIVU a=5, b=0 -> result=0xFFFFFFFF, dz=1.
  - Repeat with the macro undefined -> result=0 after 1 cycle, dz=0.
- Reset mid-op: start MUL, assert rst at cycle 10 -> no done pulse, result=0. After release, a new ADD 2+3 gives result=5.
